// File: rtl/mul_sequencer_if.sv
// Execute-stage hookup between the CPU decode/ALU-control path and the MUL sequencer.
// Handshake: a MUL request is taken in IDLE when Valid is high with the MUL encoding.
// Stall then holds the pipeline until Done pulses for the single writeback cycle.
interface mul_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             Valid;
  logic [1:0]       ALUOp;
  logic [3:0]       Funct;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             Stall;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Product;
  logic             Overflow;
  logic [1:0]       state_dbg;

  modport master (
    output Valid, ALUOp, Funct, OperandA, OperandB,
    input  Stall, Busy, Done, Product, Overflow, state_dbg
  );

  modport slave (
    input  Valid, ALUOp, Funct, OperandA, OperandB,
    output Stall, Busy, Done, Product, Overflow, state_dbg
  );
endinterface

// File: rtl/mul_sequencer.sv
// Fixed-latency shift-add multiplier for the CPU MUL instruction: latches operands,
// iterates WIDTH times while stalling, then pulses Done with the low product half.
module mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  mul_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   product;
  logic               overflow;
  logic               busy;
  logic               done;
  logic               mul_req;

  assign mul_req = bus.Valid && (bus.ALUOp == 2'b10) && (bus.Funct == 4'b0010);
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // MulReq only matters in IDLE; in DONE the same instruction is still visible.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_req) state_next = RUN;
      RUN:     if (count == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      product  <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (mul_req) begin
            mcand  <= {{WIDTH{1'b0}}, bus.OperandA};
            mplier <= bus.OperandB;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == LAST) begin
            product  <= acc_sum[WIDTH-1:0];
            overflow <= |acc_sum[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Stall     = ((state == IDLE) && mul_req) || (state == RUN);
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.Product   = product;
  assign bus.Overflow  = overflow;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: cycle-exact Stall/Busy/Done framing and
// hand-computed products checked through an expected-result queue.
module tb_mul_sequencer;
  localparam int WIDTH = 16;

  logic Clock;
  logic Reset;
  int   checks;
  int   failures;
  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH-1:0] last_product;
  logic             last_overflow;

  mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

  mul_sequencer #(.WIDTH(WIDTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] fn,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.Valid    = v;
    bus.ALUOp    = op;
    bus.Funct    = fn;
    bus.OperandA = a;
    bus.OperandB = b;
  endtask

  // Expects to be called at the negedge of the DONE cycle.
  task automatic check_done(input string tag);
    logic [WIDTH:0] exp;
    check({tag, "_ssd_done"}, {bus.Stall, bus.Busy, bus.Done}, 3'b001);
    check({tag, "_state_done"}, bus.state_dbg, 2'd2);
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check({tag, "_product"}, bus.Product, exp[WIDTH-1:0]);
      check({tag, "_overflow"}, bus.Overflow, exp[WIDTH]);
      last_product  = exp[WIDTH-1:0];
      last_overflow = exp[WIDTH];
    end
  endtask

  // Cycle 0 request, RUN cycles 1..WIDTH with scrambled inputs, DONE at WIDTH+1, IDLE after.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] ep, input logic eo, input string tag);
    int run_ok;
    exp_q.push_back({eo, ep});
    next_cycle();
    drive(1'b1, 2'b10, 4'b0010, a, b);
    @(negedge Clock);
    check({tag, "_ssd_c0"}, {bus.Stall, bus.Busy, bus.Done}, 3'b100);
    next_cycle();
    drive(1'b0, 2'b10, 4'b0010, 16'hAAAA, 16'hAAAA);
    run_ok = 1;
    for (int i = 1; i <= WIDTH; i++) begin
      @(negedge Clock);
      if ({bus.Stall, bus.Busy, bus.Done, bus.state_dbg} !== 5'b11001) run_ok = 0;
      next_cycle();
    end
    check({tag, "_run_frame"}, run_ok, 1);
    @(negedge Clock);
    check_done(tag);
    next_cycle();
    @(negedge Clock);
    check({tag, "_ssd_after"}, {bus.Stall, bus.Busy, bus.Done}, 3'b000);
    check({tag, "_product_hold"}, bus.Product, last_product);
  endtask

  task automatic non_mul(input logic v, input logic [1:0] op, input logic [3:0] fn,
                         input string tag);
    next_cycle();
    drive(v, op, fn, 16'($urandom_range(1, 16'hFFFF)), 16'($urandom_range(1, 16'hFFFF)));
    @(negedge Clock);
    check({tag, "_ssd_c0"}, {bus.Stall, bus.Busy, bus.Done}, 3'b000);
    next_cycle();
    @(negedge Clock);
    check({tag, "_ssd_c1"}, {bus.Stall, bus.Busy, bus.Done}, 3'b000);
    check({tag, "_product"}, bus.Product, last_product);
    check({tag, "_overflow"}, bus.Overflow, last_overflow);
    drive(1'b0, 2'b00, 4'b0000, '0, '0);
  endtask

  initial begin
    int seen_done;
    int run_ok;
    checks = 0;
    failures = 0;
    last_product = '0;
    last_overflow = 1'b0;
    drive(1'b0, 2'b00, 4'b0000, '0, '0);
    Reset = 1'b1;
    repeat (3) next_cycle();
    Reset = 1'b0;
    @(negedge Clock);
    check("rst_ssd", {bus.Stall, bus.Busy, bus.Done}, 3'b000);
    check("rst_product", bus.Product, 16'h0000);
    check("rst_overflow", bus.Overflow, 1'b0);
    check("rst_state", bus.state_dbg, 2'd0);

    run_mul(16'd3, 16'd5, 16'h000F, 1'b0, "mul_3x5");

    non_mul(1'b1, 2'b10, 4'b0000, "nonmul_funct");
    non_mul(1'b1, 2'b00, 4'b0010, "nonmul_aluop");
    non_mul(1'b0, 2'b10, 4'b0010, "nonmul_invalid");

    run_mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, "mul_ffff");
    run_mul(16'h0100, 16'h0100, 16'h0000, 1'b1, "mul_100");
    run_mul(16'd7, 16'd9, 16'h003F, 1'b0, "mul_stable");

    // Reset during the eighth RUN cycle discards the partial result.
    next_cycle();
    drive(1'b1, 2'b10, 4'b0010, 16'd5, 16'd5);
    next_cycle();
    drive(1'b0, 2'b10, 4'b0010, 16'hAAAA, 16'hAAAA);
    repeat (7) next_cycle();
    @(negedge Clock);
    check("rstrun_busy_c8", bus.Busy, 1'b1);
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    @(negedge Clock);
    check("rstrun_ssd", {bus.Stall, bus.Busy, bus.Done}, 3'b000);
    check("rstrun_product", bus.Product, 16'h0000);
    check("rstrun_overflow", bus.Overflow, 1'b0);
    check("rstrun_state", bus.state_dbg, 2'd0);
    last_product = '0;
    last_overflow = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 24; i++) begin
      next_cycle();
      @(negedge Clock);
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) seen_done = 1;
    end
    check("rstrun_no_done", seen_done, 0);

    run_mul(16'd2, 16'd2, 16'h0004, 1'b0, "mul_after_rst");

    // MulReq held high: ignored in DONE, restarted in the following IDLE cycle.
    exp_q.push_back({1'b0, 16'h0010});
    exp_q.push_back({1'b0, 16'h0010});
    next_cycle();
    drive(1'b1, 2'b10, 4'b0010, 16'd4, 16'd4);
    @(negedge Clock);
    check("b2b_ssd_c0", {bus.Stall, bus.Busy, bus.Done}, 3'b100);
    run_ok = 1;
    for (int i = 1; i <= WIDTH; i++) begin
      next_cycle();
      @(negedge Clock);
      if ({bus.Stall, bus.Busy, bus.Done} !== 3'b110) run_ok = 0;
    end
    check("b2b_run_frame", run_ok, 1);
    next_cycle();
    @(negedge Clock);
    check_done("b2b_first");
    next_cycle();
    @(negedge Clock);
    check("b2b_ssd_c18", {bus.Stall, bus.Busy, bus.Done}, 3'b100);
    check("b2b_state_c18", bus.state_dbg, 2'd0);
    next_cycle();
    @(negedge Clock);
    check("b2b_ssd_c19", {bus.Stall, bus.Busy, bus.Done}, 3'b110);
    drive(1'b0, 2'b00, 4'b0000, '0, '0);
    repeat (WIDTH) next_cycle();
    @(negedge Clock);
    check_done("b2b_second");

    run_mul(16'h1234, 16'h0010, 16'h2340, 1'b1, "mul_1234");
    run_mul(16'h00FF, 16'h0101, 16'hFFFF, 1'b0, "mul_00ff");

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
